cpu_sequencer: RTL and testbench

//  Multi-cycle control unit for the 8-bit computer datapath (regA, regB, shared ALU).

---
 rtl/cpu_sequencer_if.sv | 30 +++
 rtl/cpu_sequencer.sv | 118 +++++++++++
 tb/tb_cpu_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> ROM/datapath bundle; master = sequencer, slave = datapath/ROM side.
// Purely combinational signal grouping, no flow control (fixed 2-cycle schedule).
interface cpu_sequencer_if #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 7
);
  logic                   run;
  logic [PC_W-1:0]        im_addr;
  logic [OP_W+DATA_W-1:0] im_data;
  logic                   alu_zero;
  logic                   load_a;
  logic                   load_b;
  logic                   sel_a;
  logic [1:0]             sel_b;
  logic [2:0]             alu_op;
  logic [DATA_W-1:0]      lit_out;
  logic                   busy;
  logic                   halted;

  modport master (
    input  run, im_data, alu_zero,
    output im_addr, load_a, load_b, sel_a, sel_b, alu_op, lit_out, busy, halted
  );

  modport slave (
    output run, im_data, alu_zero,
    input  im_addr, load_a, load_b, sel_a, sel_b, alu_op, lit_out, busy, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Two-cycle-per-instruction control unit (FETCH, EXEC) for the 8-bit regA/regB/ALU datapath.
// Strobes are combinational from the IR during EXEC; no backpressure, run is only sampled in IDLE/HALT.
module cpu_sequencer #(
  parameter int PC_W   = 4,
  parameter int DATA_W = 8,
  parameter int OP_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_sequencer_if.master   bus
);

  localparam logic [OP_W-1:0] OP_MOV_A  = OP_W'(8'h01);
  localparam logic [OP_W-1:0] OP_MOV_B  = OP_W'(8'h02);
  localparam logic [OP_W-1:0] OP_ADD_AB = OP_W'(8'h03);
  localparam logic [OP_W-1:0] OP_SUB_AB = OP_W'(8'h04);
  localparam logic [OP_W-1:0] OP_ADD_AL = OP_W'(8'h05);
  localparam logic [OP_W-1:0] OP_JMP    = OP_W'(8'h06);
  localparam logic [OP_W-1:0] OP_JEQ    = OP_W'(8'h07);
  localparam logic [OP_W-1:0] OP_SUB_AL = OP_W'(8'h08);
  localparam logic [OP_W-1:0] OP_HALT   = OP_W'(8'h7F);

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;

  localparam logic [1:0] SELB_REG = 2'd0;
  localparam logic [1:0] SELB_LIT = 2'd1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t                 state_q, state_d;
  logic [PC_W-1:0]        pc_q, pc_d;
  logic [OP_W+DATA_W-1:0] ir_q, ir_d;
  logic                   z_q, z_d;

  logic [OP_W-1:0]        opcode;
  logic [DATA_W-1:0]      lit;
  logic                   load_a, load_b, sel_a, alu_ins;
  logic [1:0]             sel_b;
  logic [2:0]             alu_op;

  assign opcode = ir_q[OP_W+DATA_W-1:DATA_W];
  assign lit    = ir_q[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    z_d     = z_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    sel_a   = 1'b0;
    sel_b   = SELB_REG;
    alu_op  = ALU_ADD;
    alu_ins = 1'b0;

    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (bus.run) begin
          state_d = S_FETCH;
          pc_d    = '0;
          z_d     = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = bus.im_data;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_q + 1'b1;
        unique case (opcode)
          OP_MOV_A:  begin load_a = 1'b1; sel_a = 1'b1; sel_b = SELB_LIT; alu_ins = 1'b1; end
          OP_MOV_B:  begin load_b = 1'b1; sel_a = 1'b1; sel_b = SELB_LIT; alu_ins = 1'b1; end
          OP_ADD_AB: begin load_a = 1'b1; alu_ins = 1'b1; end
          OP_SUB_AB: begin load_a = 1'b1; alu_op = ALU_SUB; alu_ins = 1'b1; end
          OP_ADD_AL: begin load_a = 1'b1; sel_b = SELB_LIT; alu_ins = 1'b1; end
          OP_SUB_AL: begin load_a = 1'b1; sel_b = SELB_LIT; alu_op = ALU_SUB; alu_ins = 1'b1; end
          OP_JMP:    pc_d = lit[PC_W-1:0];
          // JEQ looks at the flag from the last ALU instruction, never the live alu_zero
          OP_JEQ:    if (z_q) pc_d = lit[PC_W-1:0];
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
        if (alu_ins) z_d = bus.alu_zero;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.im_addr = pc_q;
  assign bus.lit_out = lit;
  assign bus.load_a  = load_a;
  assign bus.load_b  = load_b;
  assign bus.sel_a   = sel_a;
  assign bus.sel_b   = sel_b;
  assign bus.alu_op  = alu_op;
  assign bus.busy    = (state_q == S_FETCH) || (state_q == S_EXEC);
  assign bus.halted  = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboarded bench: an instruction-level interpreter predicts every busy cycle's outputs,
// a negedge monitor compares them; the bench also hosts the ROM and regA/regB/ALU datapath.
module tb_cpu_sequencer;
  localparam int PC_W = 4, DATA_W = 8, OP_W = 7;
  localparam int DEPTH = 16, LIMIT = 80;

  typedef struct packed {
    logic [3:0] addr;
    logic       la;
    logic       lb;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] op;
    logic [7:0] lit;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_sequencer_if #(.PC_W(PC_W), .DATA_W(DATA_W), .OP_W(OP_W)) bus();
  cpu_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ROM and datapath environment
  logic [14:0] rom [DEPTH];
  logic [7:0]  reg_a = 8'd0, reg_b = 8'd0, op_a, op_b, alu_res;

  assign bus.im_data = rom[bus.im_addr];

  always_comb begin
    op_a = bus.sel_a ? 8'd0 : reg_a;
    case (bus.sel_b)
      2'd0:    op_b = reg_b;
      2'd1:    op_b = bus.lit_out;
      default: op_b = 8'd0;
    endcase
    case (bus.alu_op)
      3'd0:    alu_res = op_a + op_b;
      3'd1:    alu_res = op_a - op_b;
      3'd2:    alu_res = op_a & op_b;
      3'd3:    alu_res = op_a | op_b;
      3'd4:    alu_res = op_a ^ op_b;
      default: alu_res = 8'd0;
    endcase
  end
  assign bus.alu_zero = (alu_res == 8'd0);

  always @(posedge clk) begin
    if (bus.load_a) reg_a <= alu_res;
    if (bus.load_b) reg_b <= alu_res;
  end

  // scoreboard and model state
  exp_t       q[$];
  int         tests = 0, fails = 0;
  logic [7:0] m_a = 8'd0, m_b = 8'd0, m_lit = 8'd0;
  int         m_pc, m_n;
  bit         m_halt;
  exp_t       mon_act, mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.busy === 1'b1) begin
      mon_act = {bus.im_addr, bus.load_a, bus.load_b, bus.sel_a, bus.sel_b, bus.alu_op, bus.lit_out};
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_busy_cycle: got %0h expected no activity at %0t", mon_act, $time);
      end else begin
        mon_exp = q.pop_front();
        check("cycle_outputs", 32'(mon_act), 32'(mon_exp));
        check("halted_while_busy", 32'(bus.halted), 32'd0);
      end
    end
  end

  // Instruction-level interpreter: two expected records (fetch, exec) per instruction.
  task automatic model_prog();
    int         pc, nxt;
    bit         z, alu;
    logic [6:0] opc;
    logic [7:0] lit, res;
    exp_t       e;
    pc = 0; z = 0; m_n = 0; m_halt = 0;
    while (m_n < LIMIT && !m_halt) begin
      opc = rom[pc][14:8];
      lit = rom[pc][7:0];
      q.push_back({4'(pc), 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, m_lit});
      m_lit = lit;
      e = {4'(pc), 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, lit};
      alu = 1; res = 8'd0;
      case (opc)
        7'h01: begin e.la = 1; e.sa = 1; e.sb = 2'd1; res = lit; m_a = res; end
        7'h02: begin e.lb = 1; e.sa = 1; e.sb = 2'd1; res = lit; m_b = res; end
        7'h03: begin e.la = 1; res = m_a + m_b; m_a = res; end
        7'h04: begin e.la = 1; e.op = 3'd1; res = m_a - m_b; m_a = res; end
        7'h05: begin e.la = 1; e.sb = 2'd1; res = m_a + lit; m_a = res; end
        7'h08: begin e.la = 1; e.sb = 2'd1; e.op = 3'd1; res = m_a - lit; m_a = res; end
        default: alu = 0;
      endcase
      nxt = (pc + 1) % DEPTH;
      if (opc == 7'h06) nxt = int'(lit) % DEPTH;
      if (opc == 7'h07 && z) nxt = int'(lit) % DEPTH;
      if (alu) z = (res == 8'd0);
      if (opc == 7'h7F) begin m_halt = 1; nxt = pc; end
      q.push_back(e);
      m_n += 2;
      pc = nxt;
    end
    m_pc = pc;
  endtask

  // Starts the loaded program; run is also pulsed randomly while busy (must be ignored).
  task automatic run_prog(input string name);
    model_prog();
    @(posedge clk); #1 bus.run = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= m_n; c++) begin
      #1 bus.run = ($urandom_range(0, 4) == 0);
      @(posedge clk);
    end
    #1 bus.run = 1'b0;
    check({name, "_drained"}, 32'(q.size()), 32'd0);
    check({name, "_regA"}, 32'(reg_a), 32'(m_a));
    check({name, "_regB"}, 32'(reg_b), 32'(m_b));
    if (m_halt) begin
      check({name, "_halted"}, 32'(bus.halted), 32'd1);
      check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
      check({name, "_halt_pc"}, 32'(bus.im_addr), 32'(m_pc));
    end else begin
      rst_n = 1'b0;
      q.delete();
      m_lit = 8'd0;
      #1 check({name, "_rst_busy"}, 32'(bus.busy), 32'd0);
      #2 rst_n = 1'b1;
    end
  endtask

  task automatic load_rom(input logic [14:0] w0, w1, w2, w3, w4);
    for (int i = 0; i < DEPTH; i++) rom[i] = 15'd0;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3; rom[4] = w4;
  endtask

  initial begin
    logic [7:0] sav_a;
    bus.run = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom[i] = 15'd0;

    #1;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_halted", 32'(bus.halted), 32'd0);
    check("reset_addr", 32'(bus.im_addr), 32'd0);
    check("reset_strobes", 32'({bus.load_a, bus.load_b, bus.sel_a, bus.sel_b, bus.alu_op}), 32'd0);
    check("reset_lit", 32'(bus.lit_out), 32'd0);
    #12 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("idle_without_run", 32'(bus.busy), 32'd0);

    load_rom({7'h01, 8'd3}, {7'h02, 8'd2}, {7'h03, 8'd0}, {7'h7F, 8'd0}, 15'd0);
    run_prog("p1");
    check("p1_regA_5", 32'(reg_a), 32'd5);
    check("p1_regB_2", 32'(reg_b), 32'd2);

    load_rom({7'h01, 8'd3}, {7'h08, 8'd1}, {7'h07, 8'd4}, {7'h06, 8'd1}, {7'h7F, 8'd0});
    run_prog("p2");
    check("p2_regA_0", 32'(reg_a), 32'd0);
    check("p2_pc_4", 32'(bus.im_addr), 32'd4);

    // z_flag left set by p2 must be cleared by run from HALT
    load_rom({7'h07, 8'd3}, {7'h01, 8'd0}, {7'h7F, 8'd0}, {7'h7F, 8'd0}, 15'd0);
    run_prog("zclr1");
    run_prog("zclr2");
    check("zclr_pc_2", 32'(bus.im_addr), 32'd2);

    load_rom({7'h40, 8'h25}, {7'h7F, 8'd0}, 15'd0, 15'd0, 15'd0);
    run_prog("undef_op");
    check("undef_pc_1", 32'(bus.im_addr), 32'd1);

    load_rom(15'd0, 15'd0, 15'd0, 15'd0, 15'd0);
    run_prog("nop_wrap");

    // reset in the middle of an ADD A,B exec cycle
    load_rom({7'h03, 8'd0}, 15'd0, 15'd0, 15'd0, 15'd0);
    sav_a = reg_a;
    q.push_back({4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, m_lit});
    q.push_back({4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 8'd0});
    @(posedge clk); #1 bus.run = 1'b1;
    @(posedge clk); #1 bus.run = 1'b0;
    @(posedge clk);
    #1 check("mid_exec_load_a", 32'(bus.load_a), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_load_a_drop", 32'(bus.load_a), 32'd0);
    check("async_busy_drop", 32'(bus.busy), 32'd0);
    check("async_pc_zero", 32'(bus.im_addr), 32'd0);
    q.delete();
    m_lit = 8'd0;
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post_reset_idle", 32'(bus.busy), 32'd0);
    check("post_reset_regA", 32'(reg_a), 32'(sav_a));

    for (int p = 0; p < 30; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [6:0] opc;
        case ($urandom_range(0, 11))
          0: opc = 7'h00; 1: opc = 7'h01; 2: opc = 7'h02; 3: opc = 7'h03;
          4: opc = 7'h04; 5: opc = 7'h05; 6: opc = 7'h06; 7: opc = 7'h07;
          8: opc = 7'h08; 9, 10: opc = 7'h7F;
          default: opc = 7'($urandom_range(9, 126));
        endcase
        rom[i] = {opc, 8'($urandom)};
      end
      run_prog("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
